// File: rtl/sf_user_pmem_wrap.sv
// sf_user_pmem_wrap: fixed-program fixed-point processor combining a captured sample burst with host constants.
module sf_user_pmem_wrap #(
  parameter int pw = 18,
  parameter int extra = 4,
  parameter int mw = 18,
  parameter int data_len = 6,
  parameter int consts_len = 4,
  parameter int const_aw = 2
) (
  input  logic                  sf_clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [pw-1:0]         meas,
  input  logic                  trigger,
  input  logic                  h_write,
  input  logic [const_aw-1:0]   h_addr,
  input  logic [pw-1:0]         h_data,
  output logic                  ab_update,
  output logic [pw-1:0]         a_o,
  output logic [pw-1:0]         b_o,
  output logic                  cd_update,
  output logic [pw-1:0]         c_o,
  output logic [pw-1:0]         d_o,
  output logic [pw+extra-1:0]   trace,
  output logic [6:0]            trace_addr,
  output logic                  trace_strobe
);
  localparam int W = pw + extra;
  localparam int PW2 = 2 * mw + 1;
  localparam int sh = W - mw;
  localparam int psh = 2 * mw - 1 - W;
  localparam logic signed [PW2-1:0] smax = PW2'(2 ** (W - 1) - 1);
  localparam logic signed [PW2-1:0] smin = ~smax;
  typedef enum logic [1:0] {IDLE, CAPTURE, RUN} state_t;
  state_t st_q, st_d;
  logic [6:0] cnt_q, cnt_d;
  logic [W-1:0] s_q [data_len];
  logic [W-1:0] s_d [data_len];
  logic [pw-1:0] k_q [consts_len];
  logic [pw-1:0] k_d [consts_len];
  logic [W-1:0] h_q [3];
  logic [W-1:0] h_d [3];
  logic [pw-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic ab_q, ab_d, cd_q, cd_d, tr_q, tr_d;
  logic [W-1:0] trace_q, trace_d;
  logic [6:0] trace_addr_q, trace_addr_d;
  logic [W-1:0] mx, ky, res;
  logic [pw-1:0] kv;
  logic signed [PW2-1:0] mul_w, sum_w, res_w;
  logic is_mul;
  function automatic logic signed [PW2-1:0] sx(input logic [W-1:0] v);
    return PW2'($signed(v));
  endfunction
  // Step-indexed operand selection; the 3-deep history holds the most recent step results.
  always_comb begin
    mx = cnt_q == 7'd0 ? s_q[0] : cnt_q == 7'd1 ? s_q[1] : cnt_q == 7'd3 ? s_q[2] : cnt_q == 7'd4 ? s_q[3] : s_q[4];
    kv = (cnt_q == 7'd0 || cnt_q == 7'd3) ? k_q[0] : (cnt_q == 7'd1 || cnt_q == 7'd4) ? k_q[1] : k_q[2];
    ky = {kv, {extra{1'b0}}};
    mul_w = ((sx(mx) >>> sh) * (sx(ky) >>> sh)) >>> psh;
    sum_w = cnt_q == 7'd8 ? sx(s_q[5]) - sx(s_q[4])
          : cnt_q == 7'd7 ? sx(h_q[0]) + sx({k_q[3], {extra{1'b0}}})
          : sx(h_q[1]) + sx(h_q[0]);
    is_mul = cnt_q == 7'd0 || cnt_q == 7'd1 || cnt_q == 7'd3 || cnt_q == 7'd4 || cnt_q == 7'd6;
    res_w = is_mul ? mul_w : sum_w;
    res = res_w > smax ? smax[W-1:0] : res_w < smin ? smin[W-1:0] : res_w[W-1:0];
  end
  always_comb begin
    k_d = k_q;
    if (h_write && int'(h_addr) < consts_len) k_d[h_addr] = h_data;
  end
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    s_d = s_q;
    h_d = h_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    d_d = d_q;
    ab_d = ab_q;
    cd_d = cd_q;
    tr_d = tr_q;
    trace_d = trace_q;
    trace_addr_d = trace_addr_q;
    if (ce) begin
      ab_d = 1'b0;
      cd_d = 1'b0;
      tr_d = 1'b0;
      if (st_q == IDLE && trigger) begin
        st_d = CAPTURE;
        cnt_d = '0;
      end else if (st_q == CAPTURE) begin
        for (int i = 0; i < data_len - 1; i++) s_d[i] = s_q[i+1];
        s_d[data_len-1] = {meas, {extra{1'b0}}};
        cnt_d = cnt_q == 7'(data_len - 1) ? '0 : cnt_q + 7'd1;
        st_d = cnt_q == 7'(data_len - 1) ? RUN : CAPTURE;
      end else if (st_q == RUN) begin
        h_d[0] = res;
        h_d[1] = h_q[0];
        h_d[2] = h_q[1];
        tr_d = 1'b1;
        trace_d = res;
        trace_addr_d = cnt_q;
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd5) begin
          a_d = pw'($signed(h_q[2]) >>> extra);
          b_d = pw'($signed(res) >>> extra);
          ab_d = 1'b1;
        end
        if (cnt_q == 7'd8) begin
          c_d = pw'($signed(h_q[0]) >>> extra);
          d_d = pw'($signed(res) >>> extra);
          cd_d = 1'b1;
          cnt_d = '0;
          st_d = IDLE;
        end
      end
    end
  end
  always_ff @(posedge sf_clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      s_q <= '{default: '0};
      k_q <= '{default: '0};
      h_q <= '{default: '0};
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      ab_q <= 1'b0;
      cd_q <= 1'b0;
      tr_q <= 1'b0;
      trace_q <= '0;
      trace_addr_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      s_q <= s_d;
      k_q <= k_d;
      h_q <= h_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      d_q <= d_d;
      ab_q <= ab_d;
      cd_q <= cd_d;
      tr_q <= tr_d;
      trace_q <= trace_d;
      trace_addr_q <= trace_addr_d;
    end
  end
  // Strobes stay registered while frozen and are masked until ce returns.
  assign ab_update = ab_q & ce;
  assign cd_update = cd_q & ce;
  assign trace_strobe = tr_q & ce;
  assign a_o = a_q;
  assign b_o = b_q;
  assign c_o = c_q;
  assign d_o = d_q;
  assign trace = trace_q;
  assign trace_addr = trace_addr_q;
endmodule

// File: tb/tb_sf_user_pmem_wrap.sv
// tb_sf_user_pmem_wrap: table-driven runs with a model-fed scoreboard plus timing, retrigger, ce and reset sequences.
module tb_sf_user_pmem_wrap;
  logic sf_clk = 1'b0, rst = 1'b1, ce = 1'b1, trigger = 1'b0, h_write = 1'b0;
  logic [17:0] meas = '0, h_data = '0;
  logic [1:0] h_addr = '0;
  logic ab_update, cd_update, trace_strobe;
  logic [17:0] a_o, b_o, c_o, d_o;
  logic [21:0] trace;
  logic [6:0] trace_addr;
  sf_user_pmem_wrap dut (
    .sf_clk(sf_clk), .rst(rst), .ce(ce), .meas(meas), .trigger(trigger),
    .h_write(h_write), .h_addr(h_addr), .h_data(h_data),
    .ab_update(ab_update), .a_o(a_o), .b_o(b_o),
    .cd_update(cd_update), .c_o(c_o), .d_o(d_o),
    .trace(trace), .trace_addr(trace_addr), .trace_strobe(trace_strobe)
  );
  always #5 sf_clk = ~sf_clk;
  typedef struct {
    int m[6];
    int k[4];
    int ea, eb, ec, ed;
  } vec_t;
  vec_t tbl[6];
  vec_t nom;
  int checks = 0, failures = 0, cyc = 0;
  int exp_tv[$], exp_ta[$], exp_ab[$], exp_cd[$];
  int ab_n = 0, cd_n = 0, tr_n = 0, ab_cyc = 0, cd_cyc = 0, tr_first = 0, tr_last = 0, trig_cyc = 0;
  int tr_log[9];
  always @(posedge sf_clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic longint satm(input longint v);
    return v > 2097151 ? 2097151 : v < -2097152 ? -2097152 : v;
  endfunction
  function automatic longint mulm(input longint x, input longint y);
    return satm(((x >>> 4) * (y >>> 4)) >>> 13);
  endfunction
  task automatic push_model(input vec_t v);
    longint s[6], k[4], t[9];
    for (int i = 0; i < 6; i++) s[i] = longint'(v.m[i]) * 16;
    for (int i = 0; i < 4; i++) k[i] = longint'(v.k[i]) * 16;
    t[0] = mulm(s[0], k[0]);
    t[1] = mulm(s[1], k[1]);
    t[2] = satm(t[0] + t[1]);
    t[3] = mulm(s[2], k[0]);
    t[4] = mulm(s[3], k[1]);
    t[5] = satm(t[3] + t[4]);
    t[6] = mulm(s[4], k[2]);
    t[7] = satm(t[6] + k[3]);
    t[8] = satm(s[5] - s[4]);
    for (int i = 0; i < 9; i++) begin
      exp_tv.push_back(int'(t[i]));
      exp_ta.push_back(i);
    end
    exp_ab.push_back(int'(t[2] >>> 4));
    exp_ab.push_back(int'(t[5] >>> 4));
    exp_cd.push_back(int'(t[7] >>> 4));
    exp_cd.push_back(int'(t[8] >>> 4));
  endtask
  always @(negedge sf_clk) begin
    if (!ce) chk("strobe_while_ce_low", {29'd0, ab_update, cd_update, trace_strobe}, 0);
    if (trace_strobe) begin
      tr_n++;
      chk("trace_pending", exp_tv.size() > 0 ? 1 : 0, 1);
      if (exp_tv.size() > 0) begin
        chk("trace_value", int'($signed(trace)), exp_tv.pop_front());
        chk("trace_addr", int'(trace_addr), exp_ta.pop_front());
      end
      if (trace_addr < 7'd9) tr_log[trace_addr] = int'($signed(trace));
      if (trace_addr == 7'd0) tr_first = cyc;
      if (trace_addr == 7'd8) tr_last = cyc;
    end
    if (ab_update) begin
      ab_n++;
      ab_cyc = cyc;
      chk("ab_pending", exp_ab.size() >= 2 ? 1 : 0, 1);
      if (exp_ab.size() >= 2) begin
        chk("a_o", int'($signed(a_o)), exp_ab.pop_front());
        chk("b_o", int'($signed(b_o)), exp_ab.pop_front());
      end
    end
    if (cd_update) begin
      cd_n++;
      cd_cyc = cyc;
      chk("cd_pending", exp_cd.size() >= 2 ? 1 : 0, 1);
      if (exp_cd.size() >= 2) begin
        chk("c_o", int'($signed(c_o)), exp_cd.pop_front());
        chk("d_o", int'($signed(d_o)), exp_cd.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge sf_clk);
    #1;
  endtask
  task automatic run(input vec_t v, input bit retrig, input bit ce_gap, input bit rst_mid);
    int ab0, cd0, tr0;
    for (int i = 0; i < 4; i++) begin
      h_write = 1'b1;
      h_addr = 2'(i);
      h_data = 18'(v.k[i]);
      tick();
    end
    h_write = 1'b0;
    ab0 = ab_n;
    cd0 = cd_n;
    tr0 = tr_n;
    push_model(v);
    trigger = 1'b1;
    tick();
    trig_cyc = cyc;
    for (int i = 0; i < 6; i++) begin
      meas = 18'(v.m[i]);
      trigger = retrig && i == 2;
      tick();
    end
    trigger = 1'b0;
    if (ce_gap) begin
      repeat (2) tick();
      ce = 1'b0;
      repeat (5) tick();
      ce = 1'b1;
    end
    if (retrig) begin
      tick();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
    end
    if (rst_mid) begin
      repeat (3) tick();
      rst = 1'b1;
      #1;
      exp_tv.delete();
      exp_ta.delete();
      exp_ab.delete();
      exp_cd.delete();
      chk("rst_mid_a", int'(a_o), 0);
      chk("rst_mid_b", int'(b_o), 0);
      chk("rst_mid_c", int'(c_o), 0);
      chk("rst_mid_d", int'(d_o), 0);
      chk("rst_mid_trace", int'(trace), 0);
      chk("rst_mid_strobes", {29'd0, ab_update, cd_update, trace_strobe}, 0);
      repeat (4) tick();
      rst = 1'b0;
      tick();
      chk("rst_mid_ab_count", ab_n - ab0, 0);
      chk("rst_mid_cd_count", cd_n - cd0, 0);
      return;
    end
    for (int i = 0; i < 60 && cd_n == cd0; i++) tick();
    repeat (retrig ? 20 : 3) tick();
    chk("ab_count", ab_n - ab0, 1);
    chk("cd_count", cd_n - cd0, 1);
    chk("trace_count", tr_n - tr0, 9);
    chk("final_a", int'($signed(a_o)), v.ea);
    chk("final_b", int'($signed(b_o)), v.eb);
    chk("final_c", int'($signed(c_o)), v.ec);
    chk("final_d", int'($signed(d_o)), v.ed);
    if (!ce_gap) begin
      chk("ab_latency", ab_cyc - trig_cyc, 12);
      chk("cd_after_ab", cd_cyc - ab_cyc, 3);
      chk("trace_span", tr_last - tr_first, 8);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0].m = '{1000, 2000, 3000, 4000, 5000, 6000};
    tbl[0].k = '{65536, 65536, -131072, 1000};
    {tbl[0].ea, tbl[0].eb, tbl[0].ec, tbl[0].ed} = {32'sd1500, 32'sd3500, -32'sd4000, 32'sd1000};
    tbl[1].m = '{131071, 131071, 0, 0, 0, 0};
    tbl[1].k = '{131071, 131071, 0, 0};
    {tbl[1].ea, tbl[1].eb, tbl[1].ec, tbl[1].ed} = {32'sd131071, 32'sd0, 32'sd0, 32'sd0};
    tbl[2].m = '{-131072, -131072, 0, 0, 0, 0};
    tbl[2].k = '{131071, 131071, 0, 0};
    {tbl[2].ea, tbl[2].eb, tbl[2].ec, tbl[2].ed} = {-32'sd131072, 32'sd0, 32'sd0, 32'sd0};
    tbl[3].m = '{0, 0, -131072, -131072, 131071, -131072};
    tbl[3].k = '{131071, 131071, -131072, 131071};
    {tbl[3].ea, tbl[3].eb, tbl[3].ec, tbl[3].ed} = {32'sd0, -32'sd131072, 32'sd0, -32'sd131072};
    tbl[4].m = '{-131072, 0, 0, 0, 0, 0};
    tbl[4].k = '{-131072, 0, 0, 0};
    {tbl[4].ea, tbl[4].eb, tbl[4].ec, tbl[4].ed} = {32'sd131071, 32'sd0, 32'sd0, 32'sd0};
    tbl[5].m = '{-1, 0, 0, 0, 0, 7};
    tbl[5].k = '{65536, 0, 0, -5};
    {tbl[5].ea, tbl[5].eb, tbl[5].ec, tbl[5].ed} = {-32'sd1, 32'sd0, -32'sd5, 32'sd7};
    nom = tbl[0];
    repeat (3) tick();
    chk("reset_a", int'(a_o), 0);
    chk("reset_b", int'(b_o), 0);
    chk("reset_c", int'(c_o), 0);
    chk("reset_d", int'(d_o), 0);
    chk("reset_trace", int'(trace), 0);
    chk("reset_trace_addr", int'(trace_addr), 0);
    chk("reset_strobes", {29'd0, ab_update, cd_update, trace_strobe}, 0);
    rst = 1'b0;
    tick();
    for (int r = 0; r < 6; r++) begin
      run(tbl[r], 1'b0, 1'b0, 1'b0);
      if (r == 0) begin
        chk("nominal_t0", tr_log[0], 8000);
        chk("nominal_t1", tr_log[1], 16000);
        chk("nominal_t2", tr_log[2], 24000);
      end
      if (r == 1) chk("sat_pos_t2", tr_log[2], 2097151);
      if (r == 2) chk("sat_neg_t2", tr_log[2], -2097152);
    end
    run(nom, 1'b1, 1'b0, 1'b0);
    run(nom, 1'b0, 1'b1, 1'b0);
    run(nom, 1'b0, 1'b0, 1'b1);
    run(nom, 1'b0, 1'b0, 1'b0);
    chk("queues_drained", exp_tv.size() + exp_ab.size() + exp_cd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
